// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path types and constants.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int MID_TICK = 7;
    localparam int LAST_TICK = 15;

    typedef enum logic [1:0] {BAUD_9600, BAUD_19200, BAUD_57600, BAUD_115200} baud_sel_t;

    // Tick divisor for a 50 MHz clock at 16x oversampling, rounded to nearest.
    function automatic logic [15:0] baud_div(input baud_sel_t sel);
        return sel == BAUD_9600  ? 16'd326 :
               sel == BAUD_19200 ? 16'd163 :
               sel == BAUD_57600 ? 16'd54  : 16'd27;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: RxD synchroniser and bit-decision strobe.
// RX_MAJORITY_EN: 2-of-3 vote over mid-bit ticks, decided at the last tick.
module uart_rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    localparam int CW = $clog2(OVERSAMPLE)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rxd,
    input  logic          i_tick,
    input  logic          i_start,
    input  logic [CW-1:0] i_cnt,
    output logic          o_rxd_s,
    output logic          o_bit_val,
    output logic          o_bit_rdy
);

    localparam int MID  = (MID_TICK + 1) * OVERSAMPLE / OVERSAMPLE_DEFAULT - 1;
    localparam int LAST = OVERSAMPLE - 1;

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_rxd};

    assign o_rxd_s = r_sync[1];

`ifdef RX_MAJORITY_EN
    localparam int START_DEC = LAST;

    logic [2:0] r_win;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_win <= 3'b111;
        end else if (i_tick) begin
            if (i_cnt == CW'(MID))     r_win[0] <= r_sync[1];
            if (i_cnt == CW'(MID + 1)) r_win[1] <= r_sync[1];
            if (i_cnt == CW'(MID + 2)) r_win[2] <= r_sync[1];
        end

    assign o_bit_val = (r_win[0] & r_win[1]) | (r_win[0] & r_win[2]) | (r_win[1] & r_win[2]);
`else
    localparam int START_DEC = MID;

    assign o_bit_val = r_sync[1];
`endif

    assign o_bit_rdy = i_tick && (i_cnt == (i_start ? CW'(START_DEC) : CW'(LAST)));

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 8N1+parity UART receive frame sequencer on a 16x tick.
// RX_MAJORITY_EN selects majority-voted bit sampling in uart_rx_bit_sampler.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              Rx_EN,
    input  logic              RxD,
    input  logic              Rx_sample_ENABLE,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_PERROR,
    output logic              Rx_FERROR,
    output logic              Rx_BUSY
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_W);

    rx_state_t         r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_armed;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;
    logic              w_rxd_s;
    logic              w_bit_val;
    logic              w_bit_rdy;
    logic              w_par_ok;

    uart_rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .i_clk    (Clk),
        .i_rst_n  (reset),
        .i_rxd    (RxD),
        .i_tick   (Rx_sample_ENABLE),
        .i_start  (r_state == START),
        .i_cnt    (r_cnt),
        .o_rxd_s  (w_rxd_s),
        .o_bit_val(w_bit_val),
        .o_bit_rdy(w_bit_rdy)
    );

    assign w_par_ok = ((^r_shift) ^ r_par) == PARITY_ODD;

    // r_armed blocks a new start until the line has been seen high after a break.
    always_ff @(posedge Clk or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_armed <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!Rx_EN) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (Rx_sample_ENABLE) begin
                r_cnt <= r_cnt + 1'b1;
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (w_rxd_s) r_armed <= 1'b1;
                        else if (r_armed) begin
                            r_state <= START;
                            r_perr  <= 1'b0;
                            r_ferr  <= 1'b0;
                        end
                    end
                    START: if (w_bit_rdy) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_bit_val ? IDLE : DATA;
                    end
                    DATA: if (w_bit_rdy) begin
                        r_cnt   <= '0;
                        r_shift <= {w_bit_val, r_shift[DATA_W-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IW'(DATA_W - 1)) r_state <= PARITY;
                    end
                    PARITY: if (w_bit_rdy) begin
                        r_cnt   <= '0;
                        r_par   <= w_bit_val;
                        r_state <= STOP;
                    end
                    STOP: if (w_bit_rdy) begin
                        r_cnt   <= '0;
                        r_data  <= r_shift;
                        r_ferr  <= ~w_bit_val;
                        r_perr  <= ~w_par_ok;
                        r_valid <= w_bit_val & w_par_ok;
                        r_armed <= w_bit_val;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end

    assign Rx_DATA   = r_data;
    assign Rx_VALID  = r_valid;
    assign Rx_PERROR = r_perr;
    assign Rx_FERROR = r_ferr;
    assign Rx_BUSY   = r_state != IDLE;

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed and random UART frames against a frame-level model.
module tb_uart_rx_controller;

    localparam bit PARITY_ODD = 1'b0;
    localparam int BIT_CLK = 64;
    localparam int NO_ABORT = 99;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic       Rx_sample_ENABLE = 1'b0;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    int n_tot = 0;
    int n_bad = 0;
    int vcount = 0;
    int brise = 0;
    logic busy_q = 1'b0;

    uart_rx_controller dut (
        .Clk             (Clk),
        .reset           (reset),
        .Rx_EN           (Rx_EN),
        .RxD             (RxD),
        .Rx_sample_ENABLE(Rx_sample_ENABLE),
        .Rx_DATA         (Rx_DATA),
        .Rx_VALID        (Rx_VALID),
        .Rx_PERROR       (Rx_PERROR),
        .Rx_FERROR       (Rx_FERROR),
        .Rx_BUSY         (Rx_BUSY)
    );

    always #10 Clk = ~Clk;

    initial forever begin
        repeat (3) @(negedge Clk);
        Rx_sample_ENABLE = 1'b1;
        @(negedge Clk);
        Rx_sample_ENABLE = 1'b0;
    end

    always @(negedge Clk) begin
        if (Rx_VALID) vcount++;
        if (Rx_BUSY && !busy_q) brise++;
        busy_q = Rx_BUSY;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) @(negedge Clk);
    endtask

    // Leaves the line at the stop-bit level; abort_at drops Rx_EN mid data bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int abort_at);
        logic [10:0] fr;
        fr = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            RxD = fr[i];
            if (i == abort_at + 1) begin
                repeat (BIT_CLK / 2) @(negedge Clk);
                Rx_EN = 1'b0;
                @(negedge Clk);
                check("en_busy", Rx_BUSY, 0);
                repeat (BIT_CLK / 2 - 1) @(negedge Clk);
            end else begin
                repeat (BIT_CLK) @(negedge Clk);
            end
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic par, input logic stp, input int v0);
        logic perr;
        int k;
        k = 0;
        while (Rx_BUSY && k < 500) begin
            @(negedge Clk);
            k++;
        end
        check("idle_wait", Rx_BUSY, 0);
        perr = ((^d) ^ par) != PARITY_ODD;
        check("data", Rx_DATA, d);
        check("perr", Rx_PERROR, perr);
        check("ferr", Rx_FERROR, !stp);
        check("valid_cnt", vcount - v0, (!perr && stp) ? 1 : 0);
    endtask

    task automatic frame(input logic [7:0] d, input logic par, input logic stp);
        int v0;
        v0 = vcount;
        send_frame(d, par, stp, NO_ABORT);
        idle(BIT_CLK);
        expect_frame(d, par, stp, v0);
    endtask

    initial begin
        int v0;
        int b0;
        logic [7:0] d;
        logic par;
        logic stp;

        repeat (5) @(negedge Clk);
        check("rst_data", Rx_DATA, 0);
        check("rst_valid", Rx_VALID, 0);
        check("rst_perr", Rx_PERROR, 0);
        check("rst_ferr", Rx_FERROR, 0);
        check("rst_busy", Rx_BUSY, 0);
        reset = 1'b1;
        idle(4 * BIT_CLK);

        frame(8'h55, 1'b0, 1'b1);
        frame(8'hA3, 1'b1, 1'b1);
        frame(8'h0F, 1'b0, 1'b1);

        v0 = vcount;
        b0 = brise;
        send_frame(8'h3C, 1'b0, 1'b0, NO_ABORT);
        repeat (3 * 11 * BIT_CLK) @(negedge Clk);
        check("brk_starts", brise - b0, 1);
        check("brk_busy", Rx_BUSY, 0);
        expect_frame(8'h3C, 1'b0, 1'b0, v0);
        idle(2 * BIT_CLK);
        frame(8'h0F, 1'b0, 1'b1);

        v0 = vcount;
        b0 = brise;
        RxD = 1'b0;
        repeat (16) @(negedge Clk);
        idle(100);
        check("gl_starts", brise - b0, 1);
        check("gl_busy", Rx_BUSY, 0);
        check("gl_perr", Rx_PERROR, 0);
        check("gl_ferr", Rx_FERROR, 0);
        check("gl_valid", vcount - v0, 0);
        check("gl_data", Rx_DATA, 8'h0F);

        v0 = vcount;
        send_frame(8'h81, 1'b0, 1'b1, 3);
        idle(BIT_CLK);
        check("en_valid", vcount - v0, 0);
        check("en_data", Rx_DATA, 8'h0F);
        Rx_EN = 1'b1;
        idle(BIT_CLK);
        frame(8'h81, 1'b0, 1'b1);

        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            stp = $urandom_range(0, 4) != 0;
            frame(d, par, stp);
            idle(32);
        end

        d = 8'hC3;
        RxD = 1'b0;
        repeat (BIT_CLK) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            repeat (BIT_CLK) @(negedge Clk);
        end
        check("mid_busy", Rx_BUSY, 1);
        #3;
        reset = 1'b0;
        #1;
        check("ar_data", Rx_DATA, 0);
        check("ar_valid", Rx_VALID, 0);
        check("ar_perr", Rx_PERROR, 0);
        check("ar_ferr", Rx_FERROR, 0);
        check("ar_busy", Rx_BUSY, 0);
        idle(20);
        reset = 1'b1;
        idle(2 * BIT_CLK);
        frame(8'h5A, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Frame sequencer for the UART receive path. Consumes the 16x oversampling tick produced by the baud rate generator and the raw serial line. Detects the start bit, samples 8 data bits LSB-first, one parity bit and one stop bit, then reports the byte and error flags. Sits between the baud rate generator and the 7-segment/display consumer.

Parameters:
DATA_W, 8, number of data bits per frame.
OVERSAMPLE, 16, sample ticks per bit period.
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
Clk  in  1  system clock, 50 MHz.
reset  in  1  asynchronous, active-low reset.
Rx_EN  in  1  receiver enable; low forces IDLE.
RxD  in  1  raw serial line, idle high, asynchronous to Clk.
Rx_sample_ENABLE  in  1  one-Clk-wide oversampling tick from the baud rate generator.
Rx_DATA  out  DATA_W  last received byte.
Rx_VALID  out  1  one-Clk pulse: frame complete with no errors.
Rx_PERROR  out  1  parity error on last frame.
Rx_FERROR  out  1  framing error (stop bit low) on last frame.
Rx_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; tick counter, bit index and shift register cleared; Rx_DATA=0; Rx_VALID, Rx_PERROR, Rx_FERROR and Rx_BUSY all 0. The synchroniser flops reset to 1 (line idle).
- RxD passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s. Only Clk edges with Rx_sample_ENABLE==1 advance the FSM or the tick counter.
- The tick counter cnt runs 0..OVERSAMPLE-1 and is cleared on every state entry.
- IDLE: on a tick with rxd_s==0, go to START with cnt=0. Also clear Rx_PERROR and Rx_FERROR.
- START: on the tick where cnt==7 (mid-bit), if rxd_s==0 go to DATA with cnt=0 and bit index=0. Otherwise treat it as a glitch and return to IDLE with no flags set.
- DATA: on the tick where cnt==15, shift rxd_s into the shift register LSB-first. When bit index==DATA_W-1, go to PARITY. Otherwise increment the bit index.
- PARITY: on the tick where cnt==15, latch the parity bit and go to STOP.
- STOP: on the tick where cnt==15:
  - Rx_DATA <= shift register.
  - Rx_FERROR <= ~rxd_s.
  - Rx_PERROR <= (XOR of data bits ^ parity bit) != PARITY_ODD.
  - Rx_VALID pulses for exactly one Clk if both errors are 0.
  - Return to IDLE.
- Rx_DATA and the error flags hold until the next start detection. Rx_DATA is updated even on an errored frame.
- Rx_EN==0 synchronously forces IDLE and clears cnt on the next Clk edge, whatever the tick. Rx_DATA and the flags are preserved. A frame in progress is discarded with no VALID.
- Break condition: if RxD is held low, STOP sets FERROR. START is re-entered only after rxd_s has been seen high in IDLE, so a held-low line gives one FERROR, not repeated errors.
- Latency: Rx_VALID rises 1 Clk after the mid-stop-bit tick, plus 2 Clk of synchroniser delay relative to the line.

Optional Feature:
RX_MAJORITY_EN:
- Defined: each data, parity and stop bit value is the 2-of-3 majority of rxd_s captured at cnt==7, 8 and 9. The decision is made at cnt==15. START validation also uses the majority of cnt==7, 8 and 9 instead of a single sample.
- Undefined: single sample as specified above.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE_DEFAULT=16, the MID_TICK=7 and LAST_TICK=15 constants, and the baud_select encoding shared with the generator.
- One natural sub-module, uart_rx_bit_sampler: the synchroniser plus the optional majority voter. It outputs bit_val and bit_rdy to the FSM.

Test Plan:
- Even parity, tick every 4 Clk, frame 0x55 with parity 0 and stop 1 -> Rx_DATA=0x55; Rx_VALID pulses once; both error flags 0.
- Frame 0xA3 with parity bit 1 (wrong for even) -> Rx_DATA=0xA3, Rx_PERROR=1, no Rx_VALID; next good frame 0x0F clears PERROR and gives VALID.
- Frame 0x3C with stop bit 0 -> Rx_FERROR=1, no VALID; line held low 3 frame-times -> only one FERROR, no further starts until RxD returns high.
- Start glitch of 4 ticks low then high -> FSM returns to IDLE at cnt==7; Rx_BUSY drops; no flags and no VALID.
- Rx_EN deasserted at data bit 3 of frame 0x81 -> IDLE next Clk; no VALID; previous Rx_DATA retained. Re-enable, send 0x81 -> VALID.
- reset pulsed low mid-DATA -> all outputs 0 immediately (asynchronously). With RX_MAJORITY_EN, a one-tick glitch at cnt==8 of a data bit -> correct byte received.
